// File: rtl/ddr5_ca_driver.sv
// DDR5 CA launcher: buffers DFI commands and serialises 1/2-beat
// commands onto the CA bus with an optional idle gap between commands.
module ddr5_ca_driver #(
    parameter int CA_WIDTH   = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  dfi_phy_clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2*CA_WIDTH-1:0] cmd_ca_i,
    input  logic                  cmd_two_cyc_i,
    output logic [CA_WIDTH-1:0]   CA_DA_o,
    output logic                  CS_DA_o,
    output logic                  CA_VALID_DA_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  cmd_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * CA_WIDTH + 1;
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

    typedef enum logic [1:0] {
        IDLE,
        CYC2,
        GAP
    } state_t;

    state_t state, state_n;
    logic [GW-1:0] gap, gap_n;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic full, empty, push, pop;
    logic [EW-1:0] head;
    logic head_two;
    logic [CA_WIDTH-1:0] head_b1, head_b2;

    logic [CA_WIDTH-1:0] b2_q, b2_n;
    logic [CA_WIDTH-1:0] ca_n;
    logic cs_n, vld_n;

    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign push  = cmd_valid_i & ~full;

    assign cmd_ready_o = ~full;
    assign busy_o      = ~empty | (state != IDLE);

    assign head     = mem[rptr[AW-1:0]];
    assign head_two = head[EW-1];
    assign head_b1  = head[CA_WIDTH-1:0];
    assign head_b2  = head[2*CA_WIDTH-1:CA_WIDTH];

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge dfi_phy_clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= {cmd_two_cyc_i, cmd_ca_i};
    end

    always_ff @(posedge dfi_phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge dfi_phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gap           <= '0;
            b2_q          <= '0;
            CA_DA_o       <= '0;
            CS_DA_o       <= 1'b1;
            CA_VALID_DA_o <= 1'b0;
            cmd_count_o   <= '0;
        end else begin
            state         <= state_n;
            gap           <= gap_n;
            b2_q          <= b2_n;
            CA_DA_o       <= ca_n;
            CS_DA_o       <= cs_n;
            CA_VALID_DA_o <= vld_n;
            if (pop)
                cmd_count_o <= cmd_count_o + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && gap == '0) begin
                    pop = 1'b1;
                    if (head_two) begin
                        state_n = CYC2;
                    end else if (MIN_GAP > 0) begin
                        state_n = GAP;
                        gap_n   = GAP_LOAD;
                    end
                end
            end
            CYC2: begin
                if (MIN_GAP > 0) begin
                    state_n = GAP;
                    gap_n   = GAP_LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                // Counter holds the deselect cycles still owed.
                if (gap != '0)
                    gap_n = gap - GW'(1);
                if (gap <= GW'(1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ca_n  = '0;
        cs_n  = 1'b1;
        vld_n = 1'b0;
        b2_n  = b2_q;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    ca_n  = head_b1;
                    cs_n  = 1'b0;
                    vld_n = 1'b1;
                    b2_n  = head_b2;
                end
            end
            CYC2: begin
                ca_n  = b2_q;
                vld_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr5_ca_driver.sv
// Scoreboard bench for ddr5_ca_driver: one instance with no gap,
// one with a two-cycle gap, directed command vectors.
module tb_ddr5_ca_driver;

    typedef struct packed {
        logic [13:0] ca;
        logic        cs;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v0, r0, t0, cs0, vl0, b0;
    logic [27:0] d0;
    logic [13:0] ca0;
    logic [15:0] n0;

    logic        v1, r1, t1, cs1, vl1, b1;
    logic [27:0] d1;
    logic [13:0] ca1;
    logic [15:0] n1;

    int tests = 0;
    int fails = 0;

    beat_t q0[$];
    beat_t q1[$];

    ddr5_ca_driver #(.MIN_GAP(0)) dut0 (
        .dfi_phy_clk  (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (v0),
        .cmd_ready_o  (r0),
        .cmd_ca_i     (d0),
        .cmd_two_cyc_i(t0),
        .CA_DA_o      (ca0),
        .CS_DA_o      (cs0),
        .CA_VALID_DA_o(vl0),
        .busy_o       (b0),
        .cmd_count_o  (n0)
    );

    ddr5_ca_driver #(.MIN_GAP(2)) dut1 (
        .dfi_phy_clk  (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (v1),
        .cmd_ready_o  (r1),
        .cmd_ca_i     (d1),
        .cmd_two_cyc_i(t1),
        .CA_DA_o      (ca1),
        .CS_DA_o      (cs1),
        .CA_VALID_DA_o(vl1),
        .busy_o       (b1),
        .cmd_count_o  (n1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every driven beat must match the head of its scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && vl0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut0 unexpected beat: got ca=%0h none expected", ca0);
            end else begin
                e = q0.pop_front();
                chk("dut0 beat ca", 32'(ca0), 32'(e.ca));
                chk("dut0 beat cs", 32'(cs0), 32'(e.cs));
            end
        end
        if (rst_n === 1'b1 && vl1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut1 unexpected beat: got ca=%0h none expected", ca1);
            end else begin
                e = q1.pop_front();
                chk("dut1 beat ca", 32'(ca1), 32'(e.ca));
                chk("dut1 beat cs", 32'(cs1), 32'(e.cs));
            end
        end
    end

    task automatic push(input int d, input logic [13:0] p1,
                        input logic [13:0] p2, input logic two,
                        output int waits);
        waits = 0;
        if (d == 0) begin
            v0 = 1'b1; d0 = {p2, p1}; t0 = two;
        end else begin
            v1 = 1'b1; d1 = {p2, p1}; t1 = two;
        end
        while (((d == 0) ? r0 : r1) !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            tests++;
            fails++;
            $display("FAIL push timeout: got ready=0 required ready=1");
        end
        @(posedge clk);
        if (d == 0) begin
            q0.push_back(beat_t'{p1, 1'b0});
            if (two) q0.push_back(beat_t'{p2, 1'b1});
        end else begin
            q1.push_back(beat_t'{p1, 1'b0});
            if (two) q1.push_back(beat_t'{p2, 1'b1});
        end
        #1;
        if (d == 0) v0 = 1'b0;
        else v1 = 1'b0;
    endtask

    task automatic wait_vld(input int d);
        int k = 0;
        @(negedge clk);
        while (((d == 0) ? vl0 : vl1) !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            tests++;
            fails++;
            $display("FAIL wait valid dut%0d: got valid=0 required valid=1", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int w;
        int g;
        int base;
        rst_n = 1'b0;
        v0 = 0; t0 = 0; d0 = '0;
        v1 = 0; t1 = 0; d1 = '0;
        repeat (3) @(negedge clk);

        chk("rst cs", 32'(cs0), 1);
        chk("rst valid", 32'(vl0), 0);
        chk("rst ca", 32'(ca0), 0);
        chk("rst ready", 32'(r0), 1);
        chk("rst busy", 32'(b0), 0);
        chk("rst count", 32'(n0), 0);
        chk("rst cs gap", 32'(cs1), 1);
        chk("rst valid gap", 32'(vl1), 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push(0, 14'h0155, 14'h0, 1'b0, w);
        @(negedge clk);
        chk("latency pre", 32'(vl0), 0);
        @(negedge clk);
        chk("single valid", 32'(vl0), 1);
        chk("single ca", 32'(ca0), 32'h0155);
        chk("single cs", 32'(cs0), 0);
        @(negedge clk);
        chk("single after valid", 32'(vl0), 0);
        chk("single after cs", 32'(cs0), 1);
        chk("single count", 32'(n0), 1);

        push(0, 14'h1234, 14'h2AAA, 1'b1, w);
        wait_vld(0);
        chk("two beat1 ca", 32'(ca0), 32'h1234);
        chk("two beat1 cs", 32'(cs0), 0);
        @(negedge clk);
        chk("two beat2 valid", 32'(vl0), 1);
        chk("two beat2 ca", 32'(ca0), 32'h2AAA);
        chk("two beat2 cs", 32'(cs0), 1);
        @(negedge clk);
        chk("two after valid", 32'(vl0), 0);
        chk("two count", 32'(n0), 2);

        push(0, 14'h0A5A, 14'h0, 1'b0, w);
        push(0, 14'h15A5, 14'h0, 1'b0, w);
        wait_vld(0);
        @(negedge clk);
        chk("b2b valid held", 32'(vl0), 1);
        @(negedge clk);
        chk("b2b after valid", 32'(vl0), 0);
        chk("b2b count", 32'(n0), 4);

        push(1, 14'h0011, 14'h0, 1'b0, w);
        push(1, 14'h0022, 14'h0, 1'b0, w);
        wait_vld(1);
        g = 0;
        @(negedge clk);
        while (vl1 !== 1'b1 && g < 20) begin
            g++;
            @(negedge clk);
        end
        chk("gap deselect cycles", 32'(g), 2);
        repeat (4) @(negedge clk);

        base = int'(n1);
        push(1, 14'h0101, 14'h0102, 1'b1, w);
        push(1, 14'h0201, 14'h0, 1'b0, w);
        push(1, 14'h0301, 14'h0302, 1'b1, w);
        push(1, 14'h0401, 14'h0, 1'b0, w);
        push(1, 14'h0501, 14'h0, 1'b0, w);
        chk("full ready low", 32'(r1), 0);
        push(1, 14'h0601, 14'h0602, 1'b1, w);
        chk("fifth held", 32'(w >= 1), 1);
        g = 0;
        while ((b1 !== 1'b0 || vl1 !== 1'b0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain count", 32'(n1), 32'(base + 6));
        chk("drain scoreboard", 32'(q1.size()), 0);

        push(0, 14'h0A01, 14'h0A02, 1'b1, w);
        push(0, 14'h0B01, 14'h0, 1'b0, w);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(vl0), 0);
        chk("abort cs", 32'(cs0), 1);
        chk("abort ca", 32'(ca0), 0);
        chk("abort count", 32'(n0), 0);
        chk("abort busy", 32'(b0), 0);
        chk("abort ready", 32'(r0), 1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort stays idle", 32'(n0), 0);
        chk("abort not busy", 32'(b0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
